// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared widths, reset vector, NOP encoding and fetch FSM states
package instruction_fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/instruction_fetch_obuf_sr.sv
// obuf_sr: enabled output flip-flop with synchronous active-high reset to a fixed value
module obuf_sr #(
  parameter int W = 32,
  parameter logic [W-1:0] RV = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= RV;
    else if (en) q <= d;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register and request/grant/valid fetch FSM feeding instruction_decode
module instruction_fetch
  import instruction_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            phase_fetch,
  input  logic            pc_update,
  input  logic            jump_taken,
  input  logic [XLEN-1:0] jump_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] curr_pc_fd,
  output logic [XLEN-1:0] next_pc_fd,
  output logic            fetch_done,
  output logic            misaligned,
  output logic            busy
);
  fetch_state_t state, state_nxt;
  logic [XLEN-1:0] pc, fetch_addr;
  logic start, capture;
  always_comb begin
    start = state == FETCH_IDLE && phase_fetch;
    capture = imem_rvalid && ((state == FETCH_REQ && imem_gnt) || state == FETCH_WAIT);
    state_nxt = start ? FETCH_REQ :
                capture ? FETCH_IDLE :
                (state == FETCH_REQ && imem_gnt) ? FETCH_WAIT : state;
  end
  assign imem_req = state == FETCH_REQ;
  assign imem_addr = imem_req ? fetch_addr : '0;
  assign busy = state != FETCH_IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      state <= FETCH_IDLE;
      pc <= RESET_VECTOR;
      fetch_addr <= '0;
      fetch_done <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      state <= state_nxt;
      fetch_done <= capture;
      if (start) fetch_addr <= pc;
      if (pc_update) pc <= jump_taken ? {jump_target[XLEN-1:2], 2'b00} : pc + XLEN'(4);
      if (pc_update && jump_taken && |jump_target[1:0]) misaligned <= 1'b1;
    end
  // Sequencer contract: the fetch would silently use the pre-update pc
  always_ff @(posedge clk)
    if (!rst) assert (!(pc_update && phase_fetch)) else $warning("pc_update and phase_fetch coincide");
  obuf_sr #(.W(32), .RV(NOP)) u_inst (
    .clk(clk), .rst(rst), .en(capture), .d(imem_rdata), .q(inst)
  );
  obuf_sr #(.W(XLEN)) u_curr (
    .clk(clk), .rst(rst), .en(capture), .d(fetch_addr), .q(curr_pc_fd)
  );
  obuf_sr #(.W(XLEN)) u_next (
    .clk(clk), .rst(rst), .en(capture), .d(fetch_addr + XLEN'(4)), .q(next_pc_fd)
  );
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and randomized fetches checked against an architectural PC/fetch model
module tb_instruction_fetch;
  logic clk = 0, rst = 1, phase_fetch = 0, pc_update = 0, jump_taken = 0;
  logic [31:0] jump_target = 0, imem_addr, imem_rdata = 0, inst, curr_pc_fd, next_pc_fd;
  logic imem_req, imem_gnt = 0, imem_rvalid = 0, fetch_done, misaligned, busy;
  int total = 0, bad = 0;
  logic [31:0] m_pc, m_inst, m_cur, m_next;
  logic m_mis;
  instruction_fetch dut (
    .clk(clk), .rst(rst), .phase_fetch(phase_fetch), .pc_update(pc_update),
    .jump_taken(jump_taken), .jump_target(jump_target), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .inst(inst), .curr_pc_fd(curr_pc_fd),
    .next_pc_fd(next_pc_fd), .fetch_done(fetch_done), .misaligned(misaligned), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic chk_outputs(input string tag);
    chk({tag, ".inst"}, inst, m_inst);
    chk({tag, ".curr"}, curr_pc_fd, m_cur);
    chk({tag, ".next"}, next_pc_fd, m_next);
    chk({tag, ".mis"}, {31'b0, misaligned}, {31'b0, m_mis});
  endtask
  task automatic model_reset();
    m_pc = 0; m_inst = 32'h0000_0013; m_cur = 0; m_next = 0; m_mis = 0;
  endtask
  task automatic update(input logic jt, input logic [31:0] tgt);
    pc_update = 1; jump_taken = jt; jump_target = tgt;
    if (jt) begin
      m_pc = {tgt[31:2], 2'b00};
      if (tgt[1:0] != 0) m_mis = 1;
    end else m_pc = m_pc + 4;
  endtask
  task automatic idle_update(input logic jt, input logic [31:0] tgt);
    update(jt, tgt);
    step();
    pc_update = 0; jump_taken = 0;
    chk("upd.mis", {31'b0, misaligned}, {31'b0, m_mis});
  endtask
  // gd: cycles before grant; rd: cycles from grant to rvalid (0 = same cycle)
  task automatic fetch(input int gd, input int rd, input logic [31:0] data,
                       input bit upd_wait, input logic [31:0] tgt);
    logic [31:0] a;
    a = m_pc;
    phase_fetch = 1;
    step();
    phase_fetch = 0;
    chk("req.req", {31'b0, imem_req}, 1);
    chk("req.addr", imem_addr, a);
    chk("req.busy", {31'b0, busy}, 1);
    for (int i = 0; i < gd; i++) begin
      imem_rvalid = 1'($urandom);
      phase_fetch = 1'($urandom);
      imem_rdata = $urandom;
      step();
      chk("hold.req", {31'b0, imem_req}, 1);
      chk("hold.addr", imem_addr, a);
      chk("hold.done", {31'b0, fetch_done}, 0);
    end
    phase_fetch = 0;
    imem_gnt = 1; imem_rvalid = rd == 0; imem_rdata = rd == 0 ? data : $urandom;
    if (rd == 0 && upd_wait) update(1, tgt);
    step();
    imem_gnt = 0; imem_rvalid = 0; pc_update = 0; jump_taken = 0;
    if (rd > 0) begin
      chk("wait.req", {31'b0, imem_req}, 0);
      chk("wait.addr", imem_addr, 0);
      for (int i = 1; i < rd; i++) begin
        chk("wait.busy", {31'b0, busy}, 1);
        chk("wait.done", {31'b0, fetch_done}, 0);
        phase_fetch = 1'($urandom);
        step();
      end
      phase_fetch = 0;
      imem_rvalid = 1; imem_rdata = data;
      if (upd_wait) update(1, tgt);
      step();
      imem_rvalid = 0; pc_update = 0; jump_taken = 0;
    end
    m_inst = data; m_cur = a; m_next = a + 4;
    chk("cap.done", {31'b0, fetch_done}, 1);
    chk_outputs("cap");
    step();
    chk("post.done", {31'b0, fetch_done}, 0);
    chk("post.busy", {31'b0, busy}, 0);
    chk("post.req", {31'b0, imem_req}, 0);
    chk_outputs("post");
  endtask
  initial begin
    model_reset();
    step(); step();
    rst = 0;
    chk("rst.req", {31'b0, imem_req}, 0);
    chk("rst.addr", imem_addr, 0);
    chk("rst.done", {31'b0, fetch_done}, 0);
    chk("rst.busy", {31'b0, busy}, 0);
    chk_outputs("rst");
    fetch(0, 0, 32'h0050_0093, 0, 0);
    fetch(3, 2, $urandom, 0, 0);
    for (int i = 0; i < 3; i++) idle_update(0, 0);
    fetch(1, 1, $urandom, 0, 0);
    chk("seq.cur12", curr_pc_fd, 12);
    idle_update(1, 32'h0000_0102);
    chk("jmp.mis", {31'b0, misaligned}, 1);
    fetch(0, 1, $urandom, 0, 0);
    chk("jmp.cur", curr_pc_fd, 32'h100);
    fetch(1, 2, $urandom, 1, 32'h200);
    chk("redir.cur_old", curr_pc_fd, 32'h100);
    fetch(0, 0, $urandom, 0, 0);
    chk("redir.cur_new", curr_pc_fd, 32'h200);
    for (int n = 0; n < 25; n++) begin
      imem_rvalid = 1'($urandom);
      step();
      imem_rvalid = 0;
      chk("idle.done", {31'b0, fetch_done}, 0);
      if ($urandom_range(0, 1) == 1) idle_update(1'($urandom), $urandom);
      fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
            1'($urandom), $urandom);
    end
    phase_fetch = 1;
    step();
    phase_fetch = 0; imem_gnt = 1;
    step();
    imem_gnt = 0; rst = 1;
    step();
    rst = 0; imem_rvalid = 1; imem_rdata = 32'hdead_beef;
    model_reset();
    step();
    imem_rvalid = 0;
    chk("rstw.done", {31'b0, fetch_done}, 0);
    chk("rstw.busy", {31'b0, busy}, 0);
    chk("rstw.req", {31'b0, imem_req}, 0);
    chk_outputs("rstw");
    step();
    chk("rstw.done2", {31'b0, fetch_done}, 0);
    fetch(2, 0, 32'h0050_0093, 0, 0);
    chk("rstw.pc0", curr_pc_fd, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
